// File: rtl/score4_pkg.sv
// ----------------------------------------------------------------------------
// score4_pkg
// Shared types for the Score 4 win scanner:
//   cell_t        - board cell encoding (2'b11 is unused and never matches)
//   kind_t        - line direction reported by the scanner
//   scan_state_t  - scanner FSM states
//   anchor_count  - number of line anchors visited for a given board/line size
// ----------------------------------------------------------------------------
package score4_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P0    = 2'b01,
        P1    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        H = 2'b00,   // horizontal, cells (c+i, r)
        V = 2'b01,   // vertical, cells (c, r+i)
        D = 2'b10,   // down-diagonal, cells (c+i, r+i)
        U = 2'b11    // up-diagonal, cells (c+i, r-i)
    } kind_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Horizontal + vertical + both diagonal families.
    function automatic int anchor_count(input int rows, input int cols, input int win_len);
        return rows * (cols - win_len + 1)
             + cols * (rows - win_len + 1)
             + 2 * (cols - win_len + 1) * (rows - win_len + 1);
    endfunction

endpackage

// File: rtl/win_line_match.sv
// ----------------------------------------------------------------------------
// win_line_match
// Combinational check of one candidate line on a board snapshot.
// Ports:
//   panel - board snapshot, panel[col][row], 2-bit cell codes
//   col   - anchor column of the candidate line
//   row   - anchor row of the candidate line
//   kind  - line direction (H, V, D, U)
//   code  - cell code of the player being checked
//   match - all WIN_LEN cells of the line equal code
// ----------------------------------------------------------------------------
module win_line_match
    import score4_pkg::*;
#(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4
) (
    input  logic [COLS-1:0][ROWS-1:0][1:0] panel,
    input  logic [$clog2(COLS)-1:0]        col,
    input  logic [$clog2(ROWS)-1:0]        row,
    input  kind_t                          kind,
    input  logic [1:0]                     code,
    output logic                           match
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    always_comb begin
        int cc;
        int rr;
        cc    = 0;
        rr    = 0;
        match = 1'b1;
        for (int i = 0; i < WIN_LEN; i++) begin
            cc = int'(col);
            rr = int'(row);
            case (kind)
                H: cc = cc + i;
                V: rr = rr + i;
                D: begin
                    cc = cc + i;
                    rr = rr + i;
                end
                default: begin
                    cc = cc + i;
                    rr = rr - i;
                end
            endcase
            // An off-board cell can only come from an illegal anchor; treat it as no match
            // rather than reading outside the array.
            if (cc < 0 || cc >= COLS || rr < 0 || rr >= ROWS) begin
                match = 1'b0;
            end else if (panel[cc[CW-1:0]][rr[RW-1:0]] != code) begin
                match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/win_scanner.sv
// ----------------------------------------------------------------------------
// win_scanner
// Sequential WIN_LEN-in-a-row detector. A start in IDLE snapshots the board,
// then one line anchor is evaluated per clock in a fixed priority order
// (H, V, D, U). The first line owned entirely by the previous player ends the
// scan; otherwise the scan ends after the last anchor and reports a draw if
// the snapshot has no empty cell.
// Handshake: start is a request sampled only while IDLE (busy=0); a start
// seen while busy is dropped. done pulses for one cycle when the result
// outputs become valid; results then hold until the next accepted start.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   start       - scan request
//   panel       - live board, panel[col][row]
//   turn        - player to move; player ~turn is checked
//   busy        - scan in progress
//   done        - one-cycle result-valid pulse
//   exists      - winning line found
//   winner      - ~turn latched at start
//   draw        - no win and board full
//   row_out     - anchor row of the winning line
//   column_out  - anchor column of the winning line
//   kind_out    - direction of the winning line
// ----------------------------------------------------------------------------
module win_scanner
    import score4_pkg::*;
#(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [COLS-1:0][ROWS-1:0][1:0] panel,
    input  logic                           turn,
    output logic                           busy,
    output logic                           done,
    output logic                           exists,
    output logic                           winner,
    output logic                           draw,
    output logic [$clog2(ROWS)-1:0]        row_out,
    output logic [$clog2(COLS)-1:0]        column_out,
    output logic [1:0]                     kind_out
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    // Both scan counters hold either a row or a column index.
    localparam int IW = (CW > RW) ? CW : RW;

    localparam logic [IW-1:0] ROW_LAST    = IW'(ROWS - 1);
    localparam logic [IW-1:0] COL_LAST    = IW'(COLS - 1);
    localparam logic [IW-1:0] ROW_SPAN    = IW'(ROWS - WIN_LEN);
    localparam logic [IW-1:0] COL_SPAN    = IW'(COLS - WIN_LEN);
    localparam logic [IW-1:0] ROW_FIRST_U = IW'(WIN_LEN - 1);

    if (WIN_LEN < 2 || WIN_LEN > ROWS || WIN_LEN > COLS) begin : g_bad_win_len
        $error("win_scanner: WIN_LEN must satisfy 2 <= WIN_LEN <= min(ROWS, COLS)");
    end

    scan_state_t                    state;
    logic [COLS-1:0][ROWS-1:0][1:0] snap;
    logic [1:0]                     code;
    kind_t                          kind;
    logic [IW-1:0]                  outer;
    logic [IW-1:0]                  inner;

    logic [IW-1:0]                  outer_max;
    logic [IW-1:0]                  inner_max;
    logic [IW-1:0]                  inner_min;
    logic [CW-1:0]                  cur_col;
    logic [RW-1:0]                  cur_row;
    logic                           last_anchor;
    logic                           match;
    logic                           has_empty;
    kind_t                          next_kind;

    // Loop bounds and anchor coordinates for the current line family.
    // Horizontal runs row-outer; all other families run column-outer.
    always_comb begin
        outer_max = ROW_LAST;
        inner_max = COL_SPAN;
        inner_min = '0;
        cur_col   = inner[CW-1:0];
        cur_row   = outer[RW-1:0];
        case (kind)
            H: begin
            end
            V: begin
                outer_max = COL_LAST;
                inner_max = ROW_SPAN;
                cur_col   = outer[CW-1:0];
                cur_row   = inner[RW-1:0];
            end
            D: begin
                outer_max = COL_SPAN;
                inner_max = ROW_SPAN;
                cur_col   = outer[CW-1:0];
                cur_row   = inner[RW-1:0];
            end
            default: begin
                // Up-diagonals climb from row r, so r starts at WIN_LEN-1.
                outer_max = COL_SPAN;
                inner_max = ROW_LAST;
                inner_min = ROW_FIRST_U;
                cur_col   = outer[CW-1:0];
                cur_row   = inner[RW-1:0];
            end
        endcase
        next_kind   = kind_t'(kind + 2'd1);
        last_anchor = (kind == U) && (outer == outer_max) && (inner == inner_max);
    end

    always_comb begin
        has_empty = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (snap[c][r] == EMPTY) has_empty = 1'b1;
            end
        end
    end

    win_line_match #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .WIN_LEN (WIN_LEN)
    ) u_match (
        .panel (snap),
        .col   (cur_col),
        .row   (cur_row),
        .kind  (kind),
        .code  (code),
        .match (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            snap       <= '0;
            code       <= '0;
            kind       <= H;
            outer      <= '0;
            inner      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            exists     <= 1'b0;
            winner     <= 1'b0;
            draw       <= 1'b0;
            row_out    <= '0;
            column_out <= '0;
            kind_out   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap       <= panel;
                        // turn=0 means player 1 just moved, so look for its code.
                        code       <= turn ? P0 : P1;
                        winner     <= ~turn;
                        exists     <= 1'b0;
                        draw       <= 1'b0;
                        row_out    <= '0;
                        column_out <= '0;
                        kind_out   <= '0;
                        kind       <= H;
                        outer      <= '0;
                        inner      <= '0;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                default: begin
                    if (match) begin
                        exists     <= 1'b1;
                        row_out    <= cur_row;
                        column_out <= cur_col;
                        kind_out   <= kind;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (last_anchor) begin
                        draw  <= ~has_empty;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (inner == inner_max) begin
                        if (outer == outer_max) begin
                            kind  <= next_kind;
                            outer <= '0;
                            inner <= (next_kind == U) ? ROW_FIRST_U : '0;
                        end else begin
                            outer <= outer + 1'b1;
                            inner <= inner_min;
                        end
                    end else begin
                        inner <= inner + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_win_scanner.sv
// ----------------------------------------------------------------------------
// tb_win_scanner
// Directed bench for win_scanner: a default 7x6/4 instance and a 5x4/3
// instance. Expected results are queued when a scan is started; monitors pop
// and compare whenever done pulses.
// ----------------------------------------------------------------------------
module tb_win_scanner;
    import score4_pkg::*;

    typedef struct packed {
        logic [15:0] lat;
        logic        ex;
        logic        win;
        logic        drw;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [1:0]  kind;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- default instance ----------------
    logic                 start, turn;
    logic [6:0][5:0][1:0] panel;
    logic                 busy, done, exists, winner, draw;
    logic [2:0]           row_out, column_out;
    logic [1:0]           kind_out;

    win_scanner #(.COLS(7), .ROWS(6), .WIN_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .panel      (panel),
        .turn       (turn),
        .busy       (busy),
        .done       (done),
        .exists     (exists),
        .winner     (winner),
        .draw       (draw),
        .row_out    (row_out),
        .column_out (column_out),
        .kind_out   (kind_out)
    );

    // ---------------- small instance ----------------
    logic                 start_s, turn_s;
    logic [4:0][3:0][1:0] panel_s;
    logic                 busy_s, done_s, exists_s, winner_s, draw_s;
    logic [1:0]           row_out_s;
    logic [2:0]           column_out_s;
    logic [1:0]           kind_out_s;

    win_scanner #(.COLS(5), .ROWS(4), .WIN_LEN(3)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s),
        .panel      (panel_s),
        .turn       (turn_s),
        .busy       (busy_s),
        .done       (done_s),
        .exists     (exists_s),
        .winner     (winner_s),
        .draw       (draw_s),
        .row_out    (row_out_s),
        .column_out (column_out_s),
        .kind_out   (kind_out_s)
    );

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    exp_t exp_q_s[$];
    int   t_start   = 0;
    int   t_start_s = 0;
    int   busy_cnt  = 0;
    int   busy_cnt_s = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency",     cyc - t_start,    int'(e.lat));
                    chk("busy_cycles", busy_cnt,         int'(e.lat) - 1);
                    chk("exists",      int'(exists),     int'(e.ex));
                    chk("winner",      int'(winner),     int'(e.win));
                    chk("draw",        int'(draw),       int'(e.drw));
                    chk("row_out",     int'(row_out),    int'(e.row));
                    chk("column_out",  int'(column_out), int'(e.col));
                    chk("kind_out",    int'(kind_out),   int'(e.kind));
                    chk("exists_and_draw", int'(exists & draw), 0);
                end
                busy_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt_s = 0;
        end else begin
            if (busy_s) busy_cnt_s++;
            if (done_s) begin
                if (exp_q_s.size() == 0) begin
                    chk("s_unexpected_done", 1, 0);
                end else begin
                    e = exp_q_s.pop_front();
                    chk("s_latency",     cyc - t_start_s,    int'(e.lat));
                    chk("s_busy_cycles", busy_cnt_s,         int'(e.lat) - 1);
                    chk("s_exists",      int'(exists_s),     int'(e.ex));
                    chk("s_winner",      int'(winner_s),     int'(e.win));
                    chk("s_draw",        int'(draw_s),       int'(e.drw));
                    chk("s_row_out",     int'(row_out_s),    int'(e.row));
                    chk("s_column_out",  int'(column_out_s), int'(e.col));
                    chk("s_kind_out",    int'(kind_out_s),   int'(e.kind));
                end
                busy_cnt_s = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int lat, input int ex, input int win, input int drw,
                            input int r, input int c, input int k);
        exp_t e;
        e.lat  = 16'(lat);
        e.ex   = 1'(ex);
        e.win  = 1'(win);
        e.drw  = 1'(drw);
        e.row  = 3'(r);
        e.col  = 3'(c);
        e.kind = 2'(k);
        exp_q.push_back(e);
    endtask

    task automatic issue_start(input logic t);
        @(negedge clk);
        turn    = t;
        start   = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout_waiting_done", 1, 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_scan(input logic t, input int lat, input int ex, input int win,
                            input int drw, input int r, input int c, input int k);
        push_exp(lat, ex, win, drw, r, c, k);
        issue_start(t);
        wait_drain();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},       int'(busy),       0);
        chk({tag, "_done"},       int'(done),       0);
        chk({tag, "_exists"},     int'(exists),     0);
        chk({tag, "_winner"},     int'(winner),     0);
        chk({tag, "_draw"},       int'(draw),       0);
        chk({tag, "_row_out"},    int'(row_out),    0);
        chk({tag, "_column_out"}, int'(column_out), 0);
        chk({tag, "_kind_out"},   int'(kind_out),   0);
    endtask

    task automatic set_cell(input int c, input int r, input logic [1:0] v);
        panel[c][r] = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        turn    = 1'b0;
        panel   = '0;
        start_s = 1'b0;
        turn_s  = 1'b0;
        panel_s = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Empty board: full 69-anchor scan, no win, not a draw.
        panel = '0;
        run_scan(1'b0, 70, 0, 1, 0, 0, 0, 0);

        // Horizontal at row 0, columns 0..3: very first anchor.
        panel = '0;
        for (int i = 0; i < 4; i++) set_cell(i, 0, 2'b10);
        run_scan(1'b0, 2, 1, 1, 0, 0, 0, 0);

        // Vertical in column 6, rows 2..5, player 0: anchor 44.
        panel = '0;
        for (int i = 0; i < 4; i++) set_cell(6, 2 + i, 2'b01);
        run_scan(1'b1, 46, 1, 0, 0, 2, 6, 1);

        // Horizontal at row 5 (anchor 23) outranks an up-diagonal.
        panel = '0;
        for (int i = 0; i < 4; i++) set_cell(3 + i, 5, 2'b10);
        for (int i = 0; i < 4; i++) set_cell(i, 3 - i, 2'b10);
        run_scan(1'b0, 25, 1, 1, 0, 5, 3, 0);

        // Up-diagonal alone from (0,3): first up-diagonal anchor, index 57.
        panel = '0;
        for (int i = 0; i < 4; i++) set_cell(i, 3 - i, 2'b01);
        run_scan(1'b1, 59, 1, 0, 0, 3, 0, 3);

        // Line belongs to the player about to move: not reported.
        panel = '0;
        for (int i = 0; i < 4; i++) set_cell(1 + i, 2, 2'b01);
        run_scan(1'b0, 70, 0, 1, 0, 0, 0, 0);

        // Full board without any line -> draw. A start while busy (with a
        // different board and turn) must be dropped, not queued.
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                set_cell(c, r, ((((c >> 1) + r) & 1) != 0) ? 2'b10 : 2'b01);
        push_exp(70, 0, 0, 1, 0, 0, 0);
        issue_start(1'b1);
        repeat (5) @(negedge clk);
        panel = '0;
        for (int i = 0; i < 4; i++) set_cell(i, 0, 2'b10);
        turn  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (75) @(negedge clk);

        // Board changes after start are invisible to the scan.
        panel = '0;
        push_exp(70, 0, 1, 0, 0, 0, 0);
        issue_start(1'b0);
        for (int i = 0; i < 4; i++) set_cell(i, 0, 2'b10);
        wait_drain();

        // Reset during a scan: outputs clear next cycle, no done afterwards.
        panel = '0;
        issue_start(1'b0);
        while (cyc < t_start + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_rst");
        rst = 1'b0;
        repeat (90) @(negedge clk);

        // 5x4 board, 3 in a row: down-diagonal from (0,0) is anchor 22 of 34.
        panel_s = '0;
        for (int i = 0; i < 3; i++) panel_s[i][i] = 2'b10;
        begin
            exp_t e;
            e.lat  = 16'd24;
            e.ex   = 1'b1;
            e.win  = 1'b1;
            e.drw  = 1'b0;
            e.row  = 3'd0;
            e.col  = 3'd0;
            e.kind = 2'b10;
            exp_q_s.push_back(e);
        end
        @(negedge clk);
        turn_s    = 1'b0;
        start_s   = 1'b1;
        t_start_s = cyc;
        @(negedge clk);
        start_s   = 1'b0;
        begin
            int n;
            n = 0;
            while (exp_q_s.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (exp_q_s.size() != 0) begin
                chk("s_timeout_waiting_done", 1, 0);
                exp_q_s.delete();
            end
        end
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/win_scanner.md
Name: win_scanner

Overview:
- Sequential, parametrised four-in-a-row detector for the Score 4 game.
- Latches a board snapshot on start and scans every candidate line anchor, one anchor per clock.
- Reports the first winning line of the previous player, or a draw when the board is full.
- Sits between the board register file and the game-control FSM. Supports any board size and line length, replacing single-cycle full-board search with a small, timing-friendly datapath.

Parameters:
- COLS, 7, board columns (index 0..COLS-1)
- ROWS, 6, board rows (index 0..ROWS-1)
- WIN_LEN, 4, pieces in a line required to win. Elaboration fails unless 2 <= WIN_LEN <= min(ROWS,COLS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request scan; accepted only in IDLE
- panel  in  [COLS-1:0][ROWS-1:0][1:0]  board, panel[col][row]; sampled on accepted start
- turn  in  1  player now to move; the previous player (~turn) is checked
- busy  out  1  high while scanning
- done  out  1  one-cycle pulse when results are valid
- exists  out  1  winning line found
- winner  out  1  equals ~turn latched at start
- draw  out  1  no win and snapshot has no empty cell
- row_out  out  $clog2(ROWS)  anchor row of the winning line
- column_out  out  $clog2(COLS)  anchor column of the winning line
- kind_out  out  2  00 horizontal, 01 vertical, 10 down-diagonal, 11 up-diagonal

Behaviour:
- Cell encoding: 00 empty, 01 player 0, 10 player 1, 11 never matches.
- Checked code: turn=0 checks 10; turn=1 checks 01.
- Reset: state IDLE; busy, done, exists, winner, draw, row_out, column_out, kind_out all 0; counters 0.
- Accepted start (IDLE and start=1):
  - Snapshot panel, latch player code and winner=~turn.
  - Clear exists, draw, row_out, column_out and kind_out.
  - busy=1 from the next cycle.
- Start while busy is ignored; it is not queued.
- Scan order, which also sets priority (first match wins):
  - Horizontal: row outer 0..ROWS-1, column inner 0..COLS-WIN_LEN; cells (c+i, r).
  - Vertical: column outer, row inner 0..ROWS-WIN_LEN; cells (c, r+i).
  - Down-diagonal: column outer 0..COLS-WIN_LEN, row inner 0..ROWS-WIN_LEN; cells (c+i, r+i).
  - Up-diagonal: column outer 0..COLS-WIN_LEN, row inner WIN_LEN-1..ROWS-1; cells (c+i, r-i).
- Anchor count N = ROWS*(COLS-W+1) + COLS*(ROWS-W+1) + 2*(COLS-W+1)*(ROWS-W+1), where W = WIN_LEN. Defaults give N = 24+21+12+12 = 69.
- States:
  - IDLE -> SCAN on accepted start.
  - SCAN -> IDLE on match or after the last anchor.
  - Anchor k (0-based global index) is evaluated in cycle T+1+k, where T is the start cycle.
- On match at anchor k:
  - exists=1 and row/column/kind of the anchor are registered.
  - done=1 and busy=0 in cycle T+2+k.
- No match: done in cycle T+N+1; draw = snapshot contains no 00 cell.
- exists and draw are never both 1.
- Results hold until the next accepted start.
- Counter wrap: inner index reaches its maximum -> resets and outer index increments; outer reaches its maximum -> kind increments. Counter widths are sized so no count wraps before the kind transition.
- Reset mid-scan: next cycle is IDLE with all outputs 0; no done pulse.
- Start and rst in the same cycle: rst wins.
- Board changes during a scan are ignored because the snapshot is used.

Decomposition:
- score4_pkg:
  - cell_t enum: EMPTY=2'b00, P0=2'b01, P1=2'b10
  - kind_t enum: H=2'b00, V=2'b01, D=2'b10, U=2'b11
  - scan state enum: IDLE, SCAN
  - function returning the anchor count for given ROWS/COLS/WIN_LEN
- Sub-module win_line_match:
  - combinational; inputs are snapshot, anchor col/row, kind and player code
  - output is match = all WIN_LEN cells equal the player code
  - parametrised identically to win_scanner

Test Plan:
- Empty board, turn=0 -> done at T+70, exists=0, draw=0, winner=1, busy high for cycles T+1..T+69.
- Cells (0..3, row 0) = 10, turn=0 -> done at T+2, exists=1, winner=1, row_out=0, column_out=0, kind_out=00.
- Cells (col 6, rows 2..5) = 01, turn=1 -> anchor index 24+6*3+2 = 44; done at T+46, kind_out=01, column_out=6, row_out=2, winner=0.
- Board holding both a horizontal win at row 5 and an up-diagonal win -> horizontal reported (kind_out=00). Four-in-a-row of the opponent's code only -> exists=0.
- Full board with no line, then start -> draw=1, exists=0, done at T+70. A second start while busy is ignored. WIN_LEN=3, COLS=5, ROWS=4 build: diagonal (0,0),(1,1),(2,2) -> kind_out=10 with the correct latency.
- rst asserted at T+10 mid-scan -> IDLE next cycle, all outputs 0, no done pulse. Change panel during a scan -> result reflects the snapshot.
